// File: rtl/sccb_target.sv
// rtl/sccb_target.sv - SCCB register target: 3-phase writes to a strobe, 2-phase reads from a register file.
module sccb_target #(
  parameter logic [7:0] DEVICE_ID = 8'h42,
  parameter bit         ACK_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ID, S_SUB, S_DATA, S_RD, S_IGNORE
  } state_e;

  state_e     state_q, state_d;
  // [0] and [1] form the synchronizer, [2] is the previous synced level
  logic [2:0] scl_q, scl_d, sda_q, sda_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       ack_q, ack_d;
  logic       sda_oe_q, sda_oe_d;
  logic       wr_en_q, wr_en_d;
  logic [7:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic [7:0] rd_addr_q, rd_addr_d;
  logic       busy_q, busy_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rx_byte;

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_ev = scl_q[1] & sda_q[2] & ~sda_q[1];
  assign stop_ev  = scl_q[1] & ~sda_q[2] & sda_q[1];
  assign rx_byte  = {shift_q[6:0], sda_q[1]};

  always_comb begin
    scl_d     = {scl_q[1], scl_q[0], scl_in};
    sda_d     = {sda_q[1], sda_q[0], sda_in};
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    ack_d     = ack_q;
    sda_oe_d  = sda_oe_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_addr_d = rd_addr_q;
    busy_d    = busy_q;

    if (start_ev) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      ack_d     = 1'b0;
      state_d   = S_ID;
      busy_d    = 1'b1;
    end else if (stop_ev) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = 4'd0;
      ack_d     = 1'b0;
      state_d   = S_IDLE;
      busy_d    = 1'b0;
    end else if (ack_q) begin
      // State already points at the follow-on phase; this fall closes the 9th bit
      if (scl_fall) begin
        ack_d     = 1'b0;
        bit_cnt_d = 4'd0;
        sda_oe_d  = 1'b0;
        if (state_q == S_RD) begin
          shift_d   = rd_data;
          sda_oe_d  = ~rd_data[7];
          bit_cnt_d = 4'd1;
        end
      end
    end else begin
      case (state_q)
        S_ID, S_SUB, S_DATA: begin
          if (scl_rise && bit_cnt_q < 4'd8) begin
            shift_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7 && state_q == S_SUB) begin
              rd_addr_d = rx_byte;
            end
            if (bit_cnt_q == 4'd7 && state_q == S_DATA) begin
              wr_en_d   = 1'b1;
              wr_addr_d = rd_addr_q;
              wr_data_d = rx_byte;
            end
          end else if (scl_fall && bit_cnt_q == 4'd8) begin
            ack_d    = 1'b1;
            sda_oe_d = ACK_EN;
            if (state_q == S_ID) begin
              if (shift_q == DEVICE_ID) begin
                state_d = S_SUB;
              end else if (shift_q == (DEVICE_ID | 8'h01)) begin
                state_d = S_RD;
              end else begin
                state_d  = S_IGNORE;
                ack_d    = 1'b0;
                sda_oe_d = 1'b0;
              end
            end else if (state_q == S_SUB) begin
              state_d = S_DATA;
            end else begin
              state_d = S_IGNORE;
            end
          end
        end
        S_RD: begin
          if (scl_fall) begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = {shift_q[6:0], 1'b0};
              sda_oe_d  = ~shift_q[6];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              sda_oe_d = 1'b0;
              state_d  = S_IGNORE;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      scl_q     <= 3'b111;
      sda_q     <= 3'b111;
      bit_cnt_q <= 4'd0;
      shift_q   <= 8'd0;
      ack_q     <= 1'b0;
      sda_oe_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'd0;
      wr_data_q <= 8'd0;
      rd_addr_q <= 8'd0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      scl_q     <= scl_d;
      sda_q     <= sda_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      ack_q     <= ack_d;
      sda_oe_q  <= sda_oe_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_addr_q <= rd_addr_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe  = sda_oe_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sccb_target.sv
// tb/tb_sccb_target.sv - bench for sccb_target: bus-level master, transaction model, per-cycle compare.
module tb_sccb_target;

  logic       clk = 1'b0;
  logic       rst_n, scl_m, sda_m;
  logic       scl_bus, sda_bus;
  logic       sda_oe0, wr_en0, busy0, sda_oe1, wr_en1, busy1;
  logic [7:0] wr_addr0, wr_data0, rd_addr0, rd_data0;
  logic [7:0] wr_addr1, wr_data1, rd_addr1, rd_data1;
  logic [7:0] regs [256];

  int n_checks = 0;
  int n_errors = 0;
  int half;
  logic chk_en;
  logic oe1_seen = 1'b0;

  // Transaction-level model: byte index within a transaction and the ID byte that opened it
  logic [7:0] dev_id [2] = '{8'h42, 8'h5A};
  bit         ack_en [2] = '{1'b1, 1'b0};
  int         m_idx;
  logic [7:0] m_id;
  logic       pend_oe [2], exp_oe [2];
  logic [7:0] pend_rd_addr [2], exp_rd_addr [2];
  logic       pend_busy, exp_busy;
  logic [15:0] exp_wr0 [$], exp_wr1 [$], got_wr0 [$], got_wr1 [$];

  always #5 clk = ~clk;

  assign scl_bus  = scl_m;
  assign sda_bus  = sda_m & ~sda_oe0 & ~sda_oe1;
  assign rd_data0 = regs[rd_addr0];
  assign rd_data1 = regs[rd_addr1];

  sccb_target #(.DEVICE_ID(8'h42), .ACK_EN(1'b1)) dut0 (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_bus), .sda_in(sda_bus), .sda_oe(sda_oe0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0), .rd_addr(rd_addr0),
    .rd_data(rd_data0), .busy(busy0));

  sccb_target #(.DEVICE_ID(8'h5A), .ACK_EN(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .scl_in(scl_bus), .sda_in(sda_bus), .sda_oe(sda_oe1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1), .rd_addr(rd_addr1),
    .rd_data(rd_data1), .busy(busy1));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (wr_en0) got_wr0.push_back({wr_addr0, wr_data0});
    if (wr_en1) got_wr1.push_back({wr_addr1, wr_data1});
    if (sda_oe1) oe1_seen = 1'b1;
    if (chk_en) begin
      check("sda_oe0", 8'(sda_oe0), 8'(exp_oe[0]));
      check("sda_oe1", 8'(sda_oe1), 8'(exp_oe[1]));
      check("busy0", 8'(busy0), 8'(exp_busy));
      check("busy1", 8'(busy1), 8'(exp_busy));
      check("rd_addr0", rd_addr0, exp_rd_addr[0]);
      check("rd_addr1", rd_addr1, exp_rd_addr[1]);
      check("wr_en0_idle", 8'(wr_en0), 8'h00);
      check("wr_en1_idle", 8'(wr_en1), 8'h00);
    end
  end

  function automatic bit accepts(int d, int idx, logic [7:0] v);
    if (idx == 0) return (v == dev_id[d]) || (v == (dev_id[d] | 8'h01));
    if (idx == 1 || idx == 2) return m_id == dev_id[d];
    return 1'b0;
  endfunction

  // One bus edge: SCL first, SDA three clocks later if it changes, then settle and check.
  task automatic bus_step(input logic scl_v, input logic sda_v);
    chk_en = 1'b0;
    scl_m = scl_v;
    if (sda_v != sda_m) begin
      repeat (3) @(posedge clk);
      #1 sda_m = sda_v;
    end
    repeat (5) @(posedge clk);
    #1;
    exp_oe = pend_oe;
    exp_busy = pend_busy;
    exp_rd_addr = pend_rd_addr;
    chk_en = 1'b1;
    repeat (half - 8) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input bit repeated);
    if (repeated) begin
      bus_step(1'b0, 1'b1);
      bus_step(1'b1, 1'b1);
    end
    pend_busy = 1'b1;
    pend_oe = '{1'b0, 1'b0};
    m_idx = 0;
    bus_step(1'b1, 1'b0);
  endtask

  task automatic do_stop();
    bus_step(1'b0, 1'b0);
    bus_step(1'b1, 1'b0);
    chk_en = 1'b0;
    sda_m = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("busy_before_stop_latency", 8'(busy0), 8'h01);
    @(posedge clk);
    @(negedge clk);
    check("busy_after_stop_latency", 8'(busy0), 8'h00);
    check("busy1_after_stop_latency", 8'(busy1), 8'h00);
    pend_busy = 1'b0;
    pend_oe = '{1'b0, 1'b0};
    bus_step(1'b1, 1'b1);
  endtask

  task automatic send_byte(input logic [7:0] v, input int nbits, output logic ack);
    ack = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      bus_step(1'b0, v[7-i]);
      if (i == 7) begin
        for (int d = 0; d < 2; d++) begin
          if (m_idx == 2 && m_id == dev_id[d]) begin
            if (d == 0) exp_wr0.push_back({pend_rd_addr[0], v});
            else        exp_wr1.push_back({pend_rd_addr[1], v});
          end
          if (m_idx == 1 && m_id == dev_id[d]) pend_rd_addr[d] = v;
        end
      end
      bus_step(1'b1, v[7-i]);
    end
    if (nbits == 8) begin
      for (int d = 0; d < 2; d++) pend_oe[d] = ack_en[d] && accepts(d, m_idx, v);
      bus_step(1'b0, 1'b1);
      bus_step(1'b1, 1'b1);
      ack = ~sda_bus;
      if (m_idx == 0) m_id = v;
      m_idx++;
      pend_oe = '{1'b0, 1'b0};
    end
  endtask

  task automatic read_byte(input int nbits, output logic [7:0] rv);
    int drv = 0;
    bit have = 1'b0;
    logic [7:0] val;
    for (int d = 0; d < 2; d++) begin
      if (m_idx == 1 && m_id == (dev_id[d] | 8'h01)) begin
        drv = d;
        have = 1'b1;
      end
    end
    val = have ? regs[pend_rd_addr[drv]] : 8'hFF;
    rv = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      for (int d = 0; d < 2; d++) pend_oe[d] = have && (d == drv) && !val[7-i];
      bus_step(1'b0, 1'b1);
      bus_step(1'b1, 1'b1);
      rv = {rv[6:0], sda_bus};
    end
    if (nbits == 8) begin
      pend_oe = '{1'b0, 1'b0};
      bus_step(1'b0, 1'b1);
      bus_step(1'b1, 1'b1);
      m_idx++;
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_sda_oe"}, 8'(sda_oe0), 8'h00);
    check({tag, "_wr_en"}, 8'(wr_en0), 8'h00);
    check({tag, "_wr_addr"}, wr_addr0, 8'h00);
    check({tag, "_wr_data"}, wr_data0, 8'h00);
    check({tag, "_rd_addr"}, rd_addr0, 8'h00);
    check({tag, "_busy"}, 8'(busy0), 8'h00);
    check({tag, "_sda_oe1"}, 8'(sda_oe1), 8'h00);
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_wr_count0"}, 8'(got_wr0.size()), 8'(exp_wr0.size()));
    check({tag, "_wr_count1"}, 8'(got_wr1.size()), 8'(exp_wr1.size()));
    for (int i = 0; i < got_wr0.size() && i < exp_wr0.size(); i++) begin
      check({tag, "_wr_addr0"}, got_wr0[i][15:8], exp_wr0[i][15:8]);
      check({tag, "_wr_data0"}, got_wr0[i][7:0], exp_wr0[i][7:0]);
    end
    for (int i = 0; i < got_wr1.size() && i < exp_wr1.size(); i++) begin
      check({tag, "_wr_addr1"}, got_wr1[i][15:8], exp_wr1[i][15:8]);
      check({tag, "_wr_data1"}, got_wr1[i][7:0], exp_wr1[i][7:0]);
    end
    got_wr0.delete(); got_wr1.delete(); exp_wr0.delete(); exp_wr1.delete();
  endtask

  task automatic do_reset(input string tag);
    chk_en = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_checks(tag);
    @(posedge clk);
    #1 rst_n = 1'b1;
    pend_oe = '{1'b0, 1'b0};
    pend_rd_addr = '{8'h00, 8'h00};
    pend_busy = 1'b0;
    m_idx = 0;
    m_id = 8'h00;
    bus_step(scl_m, sda_m);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    logic a0, a1, a2;
    logic [7:0] rv;
    for (int i = 0; i < 256; i++) regs[i] = 8'(i) ^ 8'hC3;
    regs[8'h0A] = 8'h76;
    regs[8'h55] = 8'hA5;
    half = 20; chk_en = 1'b0; scl_m = 1'b1; sda_m = 1'b1; rst_n = 1'b0;
    m_idx = 0; m_id = 8'h00;
    pend_oe = '{1'b0, 1'b0}; pend_rd_addr = '{8'h00, 8'h00}; pend_busy = 1'b0;
    exp_oe = pend_oe; exp_rd_addr = pend_rd_addr; exp_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_checks("rst0");
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus_step(1'b1, 1'b1);

    // 3-phase write at 100 kHz (135 clk half-period)
    half = 135;
    do_start(1'b0);
    send_byte(8'h42, 8, a0); send_byte(8'h12, 8, a1); send_byte(8'h80, 8, a2);
    do_stop();
    check("t1_acks", 8'({a0, a1, a2}), 8'h07);
    check("t1_nwr", 8'(got_wr0.size()), 8'h01);
    if (got_wr0.size() > 0) begin
      check("t1_wr_addr", got_wr0[0][15:8], 8'h12);
      check("t1_wr_data", got_wr0[0][7:0], 8'h80);
    end
    check_writes("t1");

    // Foreign ID: nobody acks or writes
    half = 20;
    do_start(1'b0);
    send_byte(8'h60, 8, a0); send_byte(8'h12, 8, a1); send_byte(8'h34, 8, a2);
    do_stop();
    check("t2_acks", 8'({a0, a1, a2}), 8'h00);
    check("t2_nwr", 8'(got_wr0.size()), 8'h00);
    check_writes("t2");

    // Pointer set then read
    do_start(1'b0);
    send_byte(8'h42, 8, a0); send_byte(8'h0A, 8, a1);
    do_stop();
    do_start(1'b0);
    send_byte(8'h43, 8, a2);
    read_byte(8, rv);
    do_stop();
    check("t3_acks", 8'({a0, a1, a2}), 8'h07);
    check("t3_read", rv, 8'h76);
    check("t3_rd_addr", rd_addr0, 8'h0A);
    check_writes("t3");

    // Aborted data byte, then full write
    do_start(1'b0);
    send_byte(8'h42, 8, a0); send_byte(8'h3A, 8, a1); send_byte(8'hF0, 4, a2);
    do_stop();
    check("t4_abort_oe", 8'(sda_oe0), 8'h00);
    check("t4_abort_busy", 8'(busy0), 8'h00);
    check("t4_abort_nwr", 8'(got_wr0.size()), 8'h00);
    do_start(1'b0);
    send_byte(8'h42, 8, a0); send_byte(8'h3A, 8, a1); send_byte(8'h04, 8, a2);
    do_stop();
    check("t4_nwr", 8'(got_wr0.size()), 8'h01);
    if (got_wr0.size() > 0) begin
      check("t4_wr_addr", got_wr0[0][15:8], 8'h3A);
      check("t4_wr_data", got_wr0[0][7:0], 8'h04);
    end
    check_writes("t4");

    // Repeated START into a read, then reset in the middle of a read byte
    do_start(1'b0);
    send_byte(8'h42, 8, a0); send_byte(8'h55, 8, a1);
    do_start(1'b1);
    send_byte(8'h43, 8, a2);
    read_byte(8, rv);
    do_stop();
    check("t5_read", rv, 8'hA5);
    check("t5_rd_addr", rd_addr0, 8'h55);
    do_start(1'b0);
    send_byte(8'h43, 8, a0);
    read_byte(2, rv);
    check("t5_partial_bits", rv, 8'h02);
    check("t5_driving_before_reset", 8'(sda_oe0), 8'h01);
    do_reset("t5_rst");
    check_writes("t5");

    // ACK_EN=0 target still writes but never drives
    do_start(1'b0);
    send_byte(8'h5A, 8, a0); send_byte(8'h21, 8, a1); send_byte(8'h9C, 8, a2);
    do_stop();
    check("t6_acks", 8'({a0, a1, a2}), 8'h00);
    check("t6_nwr1", 8'(got_wr1.size()), 8'h01);
    if (got_wr1.size() > 0) begin
      check("t6_wr_addr1", got_wr1[0][15:8], 8'h21);
      check("t6_wr_data1", got_wr1[0][7:0], 8'h9C);
    end
    check("t6_nwr0", 8'(got_wr0.size()), 8'h00);
    check_writes("t6");
    check("oe1_never_driven", 8'(oe1_seen), 8'h00);

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
